// File: rtl/mem_uart_tx.sv
// mem_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO on a native CPU bus
//   clk        : single clock, all logic on posedge
//   resetn     : synchronous active-low reset
//   mem_valid, mem_addr, mem_wdata, mem_wstrb : bus request (mem_wstrb == 0 is a read)
//   mem_ready, mem_rdata                       : registered one-cycle acknowledge and read data
//   txd        : serial output, idle high
//   irq_empty  : registered, high when FIFO empty and transmitter idle
//   Map: 0x0 TXDATA (write pushes byte 0), 0x4 STATUS {count[16:8], busy, empty, full}
module mem_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        txd,
  output logic        irq_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BAUD_MAX_I = CLK_DIV - 1;
  localparam logic [15:0] BAUD_MAX = BAUD_MAX_I[15:0];
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic txd_q, txd_d, ready_q, ready_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic sel, wr, push_req, full, empty, accept, push, pop, baud_end;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};
  // ready_q gates acceptance so an acknowledge can never repeat on the next cycle
  assign sel = mem_valid && !ready_q && mem_addr[31:4] == BASE_ADDR[31:4];
  assign wr = |mem_wstrb;
  assign push_req = wr && mem_addr[3:2] == 2'd0 && mem_wstrb[0];
  assign full = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
  // a byte push into a full FIFO is held off (no acknowledge) until a slot frees
  assign accept = sel && !(push_req && full);
  assign push = accept && push_req;
  assign pop = state_q == S_IDLE && !empty;
  assign baud_end = baud_q == BAUD_MAX;
  assign status = {15'd0, 9'(cnt_q), 5'd0, state_q != S_IDLE, empty, full};
  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d = push == pop ? cnt_q : push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    ready_d = accept;
    rdata_d = !accept ? rdata_q : (!wr && mem_addr[3:2] == 2'd1) ? status : 32'd0;
    irq_d = empty && state_q == S_IDLE;
    baud_d = (state_q == S_IDLE || baud_end) ? 16'd0 : baud_q + 16'd1;
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    txd_d = txd_q;
    case (state_q)
      S_IDLE: begin
        state_d = pop ? S_START : S_IDLE;
        shift_d = pop ? fifo_q[rptr_q] : shift_q;
        txd_d = !pop;
      end
      S_START, S_DATA: if (baud_end) begin
        if (state_q == S_DATA && bit_q == 3'd7) begin
          state_d = S_STOP;
          txd_d = 1'b1;
        end else begin
          state_d = S_DATA;
          txd_d = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d = state_q == S_START ? 3'd0 : bit_q + 3'd1;
        end
      end
      default: state_d = baud_end ? S_IDLE : S_STOP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      state_q <= S_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      txd_q <= 1'b1;
      ready_q <= 1'b0;
      irq_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
      ready_q <= ready_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= mem_wdata[7:0];
  end
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign txd = txd_q;
  assign irq_empty = irq_q;
endmodule

// File: tb/tb_mem_uart_tx.sv
// tb_mem_uart_tx: random and directed bus traffic checked against a frame-level UART model
module tb_mem_uart_tx;
  localparam int DIV = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0] mem_wstrb = '0;
  logic mem_ready, txd, irq_empty;
  logic [31:0] mem_rdata;
  mem_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .txd(txd), .irq_empty(irq_empty)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  bit mon_busy = 1'b0;
  bit abort = 1'b1;
  int ack_cyc = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic wave(input logic [7:0] b, input int k);
    int i;
    i = k / DIV;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction
  function automatic logic [31:0] exp_status();
    int c;
    c = exp_q.size();
    return {15'd0, 9'(c), 5'd0, mon_busy, c == 0, c == DEPTH};
  endfunction
  // Line monitor: samples 1 time unit after each edge, decodes every frame and
  // checks its exact per-clock waveform against the next queued byte.
  initial begin
    forever begin
      @(posedge clk); #1;
      mon_busy = 1'b0;
      if (!abort && txd === 1'b0) begin
        logic [7:0] e, g;
        int err;
        bit ab;
        mon_busy = 1'b1;
        starts.push_back(cyc);
        err = 0;
        g = '0;
        ab = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          e = '0;
        end else e = exp_q.pop_front();
        for (int k = 0; k < 10*DIV; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          if (abort) begin ab = 1'b1; break; end
          if (txd !== wave(e, k)) err++;
          if (k % DIV == DIV/2 && k/DIV >= 1 && k/DIV <= 8) g[k/DIV-1] = txd;
        end
        if (ab) mon_busy = 1'b0;
        else begin
          check("frame_byte", {24'd0, g}, {24'd0, e});
          check("frame_shape", err, 0);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk); #2;
  endtask
  // One bus access; expects the acknowledge on the edge after any cycle in
  // which the request is acceptable (always for non-push, FIFO not full for push).
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int lat);
    bit is_push, free;
    int bad;
    is_push = a[3:2] == 2'd0 && s[0];
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    free = !is_push || exp_q.size() < DEPTH;
    bad = 0;
    lat = 0;
    rd = '0;
    while (lat < 2000) begin
      tick();
      lat++;
      if (mem_ready !== free) bad++;
      if (mem_ready === 1'b1) break;
      free = !is_push || exp_q.size() < DEPTH;
    end
    mem_valid = 1'b0;
    if (mem_ready !== 1'b1) check("ack_timeout", 32'd0, 32'd1);
    else begin
      rd = mem_rdata;
      ack_cyc = cyc;
      if (is_push) exp_q.push_back(d[7:0]);
      check("ack_timing", bad, 0);
      tick();
      check("ready_pulse", {31'd0, mem_ready}, 32'd0);
    end
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || mon_busy) && n < 5000);
    if (n >= 5000) check("drain_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    logic [31:0] rd, es, prev;
    int lat, s, ns, bad;
    logic [31:0] offs [3];
    offs[0] = 32'h0;
    offs[1] = 32'h8;
    offs[2] = 32'hC;
    repeat (3) tick();
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq_empty}, 32'd1);
    resetn = 1'b1;
    abort = 1'b0;
    bus(BASE, 32'h0000_00A5, 4'hF, rd, lat);
    check("irq_busy", {31'd0, irq_empty}, 32'd0);
    check("start_latency", starts.size() > 0 ? starts[$] - ack_cyc : -1, 32'd1);
    wait_idle();
    check("irq_lag", {31'd0, irq_empty}, 32'd0);
    tick();
    check("irq_idle", {31'd0, irq_empty}, 32'd1);
    bus(BASE, 32'h3C, 4'h1, rd, lat);
    bus(BASE, 32'hC3, 4'h1, rd, lat);
    wait_idle();
    check("frame_gap", starts.size() > 1 ? starts[$] - starts[$-1] : -1, 10*DIV + 1);
    for (int i = 0; i < 3; i++) bus(BASE, 32'h11 * (i + 1), 4'h1, rd, lat);
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("status_busy", rd, 32'h0000_0204);
    wait_idle();
    tick();
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("status_drained", rd, 32'h0000_0002);
    bus(BASE, 32'hFF, 4'b0010, rd, lat);
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("nostrb_status", rd, 32'h0000_0002);
    check("nostrb_txd", {31'd0, txd}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus(BASE | offs[i], 32'd0, 4'h0, rd, lat);
      check("reserved_read", rd, 32'd0);
      bus(BASE | 32'h4 + 32'(i * 4), 32'hFFFF_FFFF, 4'hF, rd, lat);
    end
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("reserved_write", rd, 32'h0000_0002);
    prev = mem_rdata;
    for (int j = 0; j < 2; j++) begin
      mem_addr = j == 0 ? BASE + 32'h100 : 32'h0;
      mem_wdata = 32'h5A;
      mem_wstrb = 4'hF;
      mem_valid = 1'b1;
      bad = 0;
      repeat (20) begin
        tick();
        if (mem_ready !== 1'b0 || mem_rdata !== prev) bad++;
      end
      mem_valid = 1'b0;
      check("nodecode", bad, 0);
    end
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("nodecode_status", rd, 32'h0000_0002);
    for (int i = 0; i < 6; i++) bus(BASE, 32'(8'hB0 + i), 4'h1, rd, lat);
    check("burst_stall", {31'd0, lat > 1}, 32'd1);
    wait_idle();
    for (int i = 0; i < 3; i++) bus(BASE, 32'(8'h71 + i), 4'h1, rd, lat);
    s = starts.size() > 0 ? starts[$] : cyc;
    while (cyc < s + 4*DIV + 1) tick();
    abort = 1'b1;
    resetn = 1'b0;
    tick();
    check("midrst_txd", {31'd0, txd}, 32'd1);
    check("midrst_ready", {31'd0, mem_ready}, 32'd0);
    resetn = 1'b1;
    exp_q.delete();
    abort = 1'b0;
    check("midrst_irq", {31'd0, irq_empty}, 32'd1);
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("midrst_status", rd, 32'h0000_0002);
    ns = starts.size();
    repeat (30*DIV) tick();
    check("midrst_no_frame", starts.size() - ns, 32'd0);
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        logic [3:0] st;
        st = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'b0001 | 4'($urandom);
        bus(BASE, $urandom, st, rd, lat);
      end else if (op < 7) begin
        es = exp_status();
        bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
        check("status_rand", rd, es);
      end else if (op == 7) begin
        bus(BASE | offs[$urandom_range(0, 2)], 32'd0, 4'h0, rd, lat);
        check("reserved_rand", rd, 32'd0);
      end else if (op == 8) begin
        bus(BASE | offs[$urandom_range(1, 2)] - 32'(4 * $urandom_range(0, 1)), $urandom, 4'hF, rd, lat);
      end else repeat ($urandom_range(1, 30*DIV)) tick();
    end
    wait_idle();
    tick();
    check("final_irq", {31'd0, irq_empty}, 32'd1);
    bus(BASE | 32'h4, 32'd0, 4'h0, rd, lat);
    check("final_status", rd, 32'h0000_0002);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_uart_tx.md
MEM_UART_TX -- requirements
Module: mem_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: peripheral base; decode on mem_addr[31:4] == BASE_ADDR[31:4].
REQ-002 SHALL have parameter CLK_DIV, default 868: clocks per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: TX FIFO entries; power of two, 2..256.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 resetn  input  1  reset; synchronous and active-low.
REQ-006 mem_valid  input  1  CPU native-bus request valid.
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_wstrb  input  4  byte write strobes; 4'b0000 = read.
REQ-010 mem_ready  output  1  registered one-cycle acknowledge.
REQ-011 mem_rdata  output  32  registered read data, valid while mem_ready=1.
REQ-012 txd  output  1  UART serial out, 8N1, idle high.
REQ-013 irq_empty  output  1  registered; high when FIFO empty and transmitter idle.

Function
REQ-014 Request accepted only when mem_valid=1, mem_ready=0, address decodes; non-decoding requests SHALL leave mem_ready=0 and mem_rdata unchanged.
REQ-015 mem_ready SHALL pulse high exactly one cycle, asserted on the edge after acceptance; never two consecutive cycles.
REQ-016 Offset 0x0 TXDATA write with mem_wstrb[0]=1: push mem_wdata[7:0] on the acknowledging edge; mem_wstrb[0]=0: acknowledge, no push.
REQ-017 TXDATA write while FIFO full SHALL stall (mem_ready held 0) until an entry is free, then accept and push normally; no byte ever dropped.
REQ-018 Offset 0x4 STATUS read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bits[16:8] FIFO count, others 0; values sampled at acceptance.
REQ-019 Reads of 0x0, 0x8, 0xC SHALL return 0; writes to 0x4/0x8/0xC SHALL be acknowledged with no effect.
REQ-020 TX FSM states IDLE, START, DATA, STOP; bit counter 0..7, baud counter 0..CLK_DIV-1.
REQ-021 IDLE: txd=1; if FIFO non-empty, pop head into shift register, go START, drive txd=0 on that same edge.
REQ-022 START/DATA/STOP: each bit held exactly CLK_DIV clocks; DATA sends LSB first, 8 bits; STOP drives txd=1 for CLK_DIV clocks then IDLE.
REQ-023 Frame length SHALL be exactly 10*CLK_DIV clocks; STOP->IDLE->next START costs one extra clock (back-to-back frames separated by 10*CLK_DIV+1 clocks start-to-start).
REQ-024 Latency: txd falls on the edge after the mem_ready-rising edge when FSM idle and FIFO previously empty.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 irq_empty SHALL update on the edge after the condition changes.

Reset
REQ-027 On clk edge with resetn=0: mem_ready=0, mem_rdata=0, txd=1, irq_empty=1, FIFO empty, pointers/count 0, FSM IDLE, counters 0.
REQ-028 Reset mid-frame SHALL abort the frame; txd=1 from the reset edge; queued bytes discarded; pending stalled write not acknowledged.
REQ-029 First request may be accepted on the first edge after resetn returns high.

Verification
REQ-030 CLK_DIV=4: write 32'h0000_00A5 to BASE -> mem_ready 1 clock later; txd pattern 0,1,0,1,0,0,1,0,1,1 each 4 clocks (40 clocks), then irq_empty=1.
REQ-031 FIFO_DEPTH=4, CLK_DIV=8: write 6 bytes back-to-back -> writes 1-5 acked (one popped), write 6 stalls until a pop frees a slot; all 6 bytes appear on txd in order.
REQ-032 Read STATUS after 3 writes with FSM busy -> mem_rdata=32'h0000_0204 (count 2, busy); after drain -> 32'h0000_0002.
REQ-033 Access to BASE+0x100 and 32'h0000_0000 -> mem_ready stays 0 for 20 clocks, mem_rdata unchanged.
REQ-034 Assert resetn=0 mid-DATA bit 3 for one clock -> txd=1 next edge, STATUS reads 32'h0000_0002, no further frame emitted.
REQ-035 TXDATA write with mem_wstrb=4'b0010 -> acknowledged, count stays 0, txd stays 1.
